mipi_rx_frame_checker: RTL and testbench
========================================

// Module: mipi_rx_frame_checker
// PURPOSE
//   Sink-side checker for the MIPI RX pixel interface. Consumes VSYNC/HSYNC/VALID/DATA/TYPE
//   from the RX Interface Designer instance, tracks frame/line structure and checks payload
//   against the camera-mockup test pattern (six identical RAW10 pixels per beat, +1 per beat).
//   Status drives LEDs and loopback self-test.
// PARAMETERS
//   HRES          600    pixels per line
//   PIX_PER_BEAT  6      pixels per 64-bit data beat
//   PIX_W         10     bits per pixel (RAW10)
//   EXP_LINES     1      lines per frame
//   EXP_TYPE      6'h2B  expected data type (RAW10)
//   FIRST_VAL     1      pixel value of first beat in each line
// PORTS
//   rx_pixel_clk  in   1   pixel clock, all logic on rising edge
//   rst           in   1   asynchronous, active-high reset
//   rx_vsync      in   1   frame-valid level from RX
//   rx_hsync      in   1   line-valid level from RX
//   rx_valid      in   1   data beat qualifier
//   rx_data       in   64  beat payload; pixel k = rx_data[k*10+:10], k=0..5; [63:60] ignored
//   rx_type       in   6   data type of current line
//   clr_err       in   1   sync pulse: clears sticky flags and err_cnt
//   frame_done    out  1   one-cycle pulse when a frame closes
//   frame_cnt     out  16  frames closed since reset, wraps
//   line_cnt      out  16  lines closed in current/last frame
//   beat_cnt      out  16  beats in current/last line
//   err_data      out  1   sticky: pixel mismatch
//   err_len       out  1   sticky: line beat count != HRES/PIX_PER_BEAT
//   err_lines     out  1   sticky: frame line count != EXP_LINES
//   err_type      out  1   sticky: rx_type != EXP_TYPE on a valid beat
//   err_proto     out  1   sticky: sync/valid ordering violation
//   err_cnt       out  16  total error events, saturates at 16'hFFFF
//   pass          out  1   high when frame_cnt!=0 and no sticky flag set
// BEHAVIOUR
//   - Reset: all outputs 0; state IDLE; vsync_q/hsync_q registered history reset to 1 so a
//     level already high at reset release is not taken as a rising edge.
//   - States: IDLE -> (vsync rise) FRAME -> (hsync rise) LINE -> (hsync fall) FRAME
//     -> (vsync fall) IDLE. Edges from 1-cycle delayed copies of rx_vsync/rx_hsync.
//   - IDLE->FRAME clears line_cnt. FRAME->LINE clears beat_cnt, exp <= FIRST_VAL.
//   - LINE, rx_valid=1: compare all 6 pixels to exp (PIX_W bits); any mismatch -> err_data,
//     one err_cnt increment per beat; exp <= exp+1 mod 2^PIX_W (1023 -> 0);
//     beat_cnt+1; rx_type checked the same cycle.
//   - hsync fall: line_cnt+1; beat_cnt != HRES/PIX_PER_BEAT (100) -> err_len.
//   - vsync fall: frame_cnt+1, frame_done pulse next cycle; line_cnt != EXP_LINES -> err_lines.
//   - hsync and vsync fall same cycle: close line first, then frame; both checks apply.
//   - err_proto: rx_valid=1 outside LINE; hsync rise while vsync low; vsync fall in LINE is
//     NOT proto (handled as above). Proto beats are not data-checked.
//   - Latency: flags/counters update 1 cycle after offending input sample.
//   - Multiple errors in one cycle: each flag set, err_cnt += number of distinct error kinds.
//   - clr_err coincident with new error: new error wins (flag set, err_cnt=count of new).
//   - Async reset mid-frame: everything to reset values; stream resumes only at next vsync rise
//     after vsync has been seen low.
// TESTING
//   1 clean frame: vsync, 1 line of 100 beats values 1..100 -> frame_done 1 pulse,
//     frame_cnt=1, line_cnt=1, beat_cnt=100, all err 0, pass=1.
//   Beat 37 pixel 3 = 0 -> err_data=1, err_cnt=1, err_len=0, pass=0; clr_err -> all 0.
//   Line with 99 beats -> err_len=1, err_cnt=1; 2 lines with EXP_LINES=1 -> err_lines=1.
//   rx_valid pulse with hsync low inside frame -> err_proto=1, beat_cnt unchanged.
//   FIRST_VAL=1020, 100 beats wrapping 1023->0 -> no err_data.
//   rst asserted at beat 50, released with vsync high -> no counting until vsync low then high;
//     next clean frame -> frame_cnt=1, pass=1.

Source files
------------

// File: rtl/mipi_rx_frame_checker_if.sv
// Pixel-interface bundle between the MIPI RX instance (master) and its sink-side checker (slave).
interface mipi_rx_frame_checker_if;
  logic        rx_vsync;
  logic        rx_hsync;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic [5:0]  rx_type;

  modport master (output rx_vsync, rx_hsync, rx_valid, rx_data, rx_type);
  modport slave  (input  rx_vsync, rx_hsync, rx_valid, rx_data, rx_type);
endinterface

// File: rtl/mipi_rx_frame_checker.sv
// Sink-side frame checker: tracks VSYNC/HSYNC structure and checks the incrementing RAW10
// test pattern, keeping sticky error flags, an error-event counter and a pass indication.
module mipi_rx_frame_checker #(
  parameter int         HRES         = 600,
  parameter int         PIX_PER_BEAT = 6,
  parameter int         PIX_W        = 10,
  parameter int         EXP_LINES    = 1,
  parameter logic [5:0] EXP_TYPE     = 6'h2B,
  parameter int         FIRST_VAL    = 1
) (
  input  logic                   rx_pixel_clk,
  input  logic                   rst,
  mipi_rx_frame_checker_if.slave rx,
  input  logic                   clr_err,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            line_cnt,
  output logic [15:0]            beat_cnt,
  output logic                   err_data,
  output logic                   err_len,
  output logic                   err_lines,
  output logic                   err_type,
  output logic                   err_proto,
  output logic [15:0]            err_cnt,
  output logic                   pass
);

  localparam int               DATA_W     = 64;
  localparam logic [15:0]      LINE_BEATS = 16'(HRES / PIX_PER_BEAT);
  localparam logic [15:0]      LINES_EXP  = 16'(EXP_LINES);
  localparam logic [PIX_W-1:0] FIRST_PIX  = PIX_W'(FIRST_VAL);

  typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

  state_t           state_q, state_d;
  logic             vsync_q, hsync_q, armed;
  logic             vs_rise, vs_fall, hs_rise, hs_fall;
  logic             start_frame, start_line, close_line, close_frame, data_beat;
  logic [PIX_W-1:0] exp_q;
  logic             pix_mismatch;
  logic             e_data, e_len, e_lines, e_type, e_proto;
  logic [2:0]       n_err;
  logic [15:0]      beat_next, line_next, err_base;
  logic [16:0]      err_sum;
  logic             unused_hi;

  assign unused_hi = ^rx.rx_data[DATA_W-1:PIX_PER_BEAT*PIX_W];

  assign vs_rise = rx.rx_vsync & ~vsync_q;
  assign vs_fall = ~rx.rx_vsync & vsync_q;
  assign hs_rise = rx.rx_hsync & ~hsync_q;
  assign hs_fall = ~rx.rx_hsync & hsync_q;

  // Sync history resets high so a level already asserted at reset release is not an edge;
  // armed stays low until vsync has been seen low, muting protocol checks mid-stream.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b1;
      hsync_q <= 1'b1;
      armed   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of process ordering.
      vsync_q <= rx.rx_vsync;
      hsync_q <= rx.rx_hsync;
      if (!rx.rx_vsync) armed <= 1'b1;
    end
  end

  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vs_rise) state_d = FRAME;
      FRAME:   if (vs_fall) state_d = IDLE;
               else if (hs_rise && rx.rx_vsync) state_d = LINE;
      LINE:    if (vs_fall) state_d = IDLE;
               else if (hs_fall) state_d = FRAME;
      default: state_d = IDLE;
    endcase
  end

  // A vsync fall inside a line closes the line and then the frame in the same cycle.
  always_comb begin
    start_frame = (state_q == IDLE) && vs_rise;
    start_line  = (state_q == FRAME) && !vs_fall && hs_rise && rx.rx_vsync;
    close_line  = (state_q == LINE) && (hs_fall || vs_fall);
    close_frame = (state_q != IDLE) && vs_fall;
    data_beat   = (state_q == LINE) && rx.rx_hsync && rx.rx_valid;
  end

  always_comb begin
    pix_mismatch = 1'b0;
    for (int k = 0; k < PIX_PER_BEAT; k++) begin
      if (rx.rx_data[k*PIX_W +: PIX_W] != exp_q) pix_mismatch = 1'b1;
    end
  end

  assign beat_next = beat_cnt + {15'd0, data_beat};
  assign line_next = line_cnt + {15'd0, close_line};

  assign e_data  = data_beat && pix_mismatch;
  assign e_type  = data_beat && (rx.rx_type != EXP_TYPE);
  assign e_len   = close_line && (beat_next != LINE_BEATS);
  assign e_lines = close_frame && (line_next != LINES_EXP);
  assign e_proto = armed && ((rx.rx_valid && !data_beat) || (hs_rise && !rx.rx_vsync));

  assign n_err    = {2'd0, e_data} + {2'd0, e_len} + {2'd0, e_lines}
                  + {2'd0, e_type} + {2'd0, e_proto};
  assign err_base = clr_err ? 16'd0 : err_cnt;
  assign err_sum  = {1'b0, err_base} + {14'd0, n_err};

  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      exp_q      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_cnt   <= '0;
      beat_cnt   <= '0;
      err_data   <= 1'b0;
      err_len    <= 1'b0;
      err_lines  <= 1'b0;
      err_type   <= 1'b0;
      err_proto  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      frame_done <= close_frame;
      frame_cnt  <= frame_cnt + {15'd0, close_frame};
      line_cnt   <= start_frame ? 16'd0 : line_next;
      beat_cnt   <= start_line ? 16'd0 : beat_next;

      if (start_line)     exp_q <= FIRST_PIX;
      else if (data_beat) exp_q <= exp_q + PIX_W'(1);

      // A fresh error in the clearing cycle survives the clear.
      err_data  <= (err_data  & ~clr_err) | e_data;
      err_len   <= (err_len   & ~clr_err) | e_len;
      err_lines <= (err_lines & ~clr_err) | e_lines;
      err_type  <= (err_type  & ~clr_err) | e_type;
      err_proto <= (err_proto & ~clr_err) | e_proto;
      err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign pass = (frame_cnt != 16'd0)
             && !(err_data || err_len || err_lines || err_type || err_proto);

endmodule

// File: tb/tb_mipi_rx_frame_checker.sv
// Directed bench for mipi_rx_frame_checker: default instance plus a FIRST_VAL=1020 instance
// sharing one RX bus, with hand-computed expectations after each step.
module tb_mipi_rx_frame_checker;

  logic clk = 1'b0;
  logic rst;
  logic clr_err;
  always #5 clk = ~clk;

  mipi_rx_frame_checker_if bus ();

  logic        a_done, a_err_data, a_err_len, a_err_lines, a_err_type, a_err_proto, a_pass;
  logic [15:0] a_frames, a_lines, a_beats, a_err_cnt;
  logic        b_done, b_err_data, b_err_len, b_err_lines, b_err_type, b_err_proto, b_pass;
  logic [15:0] b_frames, b_lines, b_beats, b_err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  mipi_rx_frame_checker dut (
    .rx_pixel_clk(clk), .rst(rst), .rx(bus), .clr_err(clr_err),
    .frame_done(a_done), .frame_cnt(a_frames), .line_cnt(a_lines), .beat_cnt(a_beats),
    .err_data(a_err_data), .err_len(a_err_len), .err_lines(a_err_lines),
    .err_type(a_err_type), .err_proto(a_err_proto), .err_cnt(a_err_cnt), .pass(a_pass)
  );

  mipi_rx_frame_checker #(.FIRST_VAL(1020)) dut_wrap (
    .rx_pixel_clk(clk), .rst(rst), .rx(bus), .clr_err(clr_err),
    .frame_done(b_done), .frame_cnt(b_frames), .line_cnt(b_lines), .beat_cnt(b_beats),
    .err_data(b_err_data), .err_len(b_err_len), .err_lines(b_err_lines),
    .err_type(b_err_type), .err_proto(b_err_proto), .err_cnt(b_err_cnt), .pass(b_pass)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [9:0] v, input int bad_pix, input logic [5:0] typ);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 6; k++) d[k*10 +: 10] = (k == bad_pix) ? 10'd0 : v;
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    bus.rx_type  = typ;
    tick();
  endtask

  task automatic send_line(input int nbeats, input int first, input int bad_beat);
    bus.rx_hsync = 1'b1;
    tick();
    for (int i = 1; i <= nbeats; i++)
      drive_beat(10'(first + i - 1), (i == bad_beat) ? 3 : -1, 6'h2B);
    bus.rx_valid = 1'b0;
    bus.rx_hsync = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int nlines, input int nbeats, input int first, input int bad_beat);
    bus.rx_vsync = 1'b1;
    tick();
    for (int l = 0; l < nlines; l++) send_line(nbeats, first, bad_beat);
    bus.rx_vsync = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_err = 1'b0;
    bus.rx_vsync = 1'b0;
    bus.rx_hsync = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.rx_type  = 6'h2B;
    tick();
    tick();
    check("reset frame_cnt", a_frames, 0);
    check("reset err_cnt", a_err_cnt, 0);
    check("reset pass", a_pass, 0);
    check("reset frame_done", a_done, 0);
    rst = 1'b0;
    tick();
    tick();

    // Clean frame: one line of 100 beats, values 1..100.
    send_frame(1, 100, 1, 0);
    check("clean frame_done", a_done, 1);
    check("clean frame_cnt", a_frames, 1);
    check("clean line_cnt", a_lines, 1);
    check("clean beat_cnt", a_beats, 100);
    check("clean err_cnt", a_err_cnt, 0);
    check("clean flags", {a_err_data, a_err_len, a_err_lines, a_err_type, a_err_proto}, 0);
    check("clean pass", a_pass, 1);
    tick();
    check("frame_done one pulse", a_done, 0);

    // Beat 37 pixel 3 forced to zero.
    send_frame(1, 100, 1, 37);
    check("bad pixel err_data", a_err_data, 1);
    check("bad pixel err_cnt", a_err_cnt, 1);
    check("bad pixel err_len", a_err_len, 0);
    check("bad pixel pass", a_pass, 0);
    pulse_clr();
    check("clr err_data", a_err_data, 0);
    check("clr err_cnt", a_err_cnt, 0);
    check("clr pass", a_pass, 1);

    // Short line of 99 beats.
    bus.rx_vsync = 1'b1;
    tick();
    send_line(99, 1, 0);
    check("short line err_len", a_err_len, 1);
    check("short line err_cnt", a_err_cnt, 1);
    check("short line beat_cnt", a_beats, 99);
    bus.rx_vsync = 1'b0;
    tick();
    check("short line err_lines", a_err_lines, 0);
    check("short line frame_cnt", a_frames, 3);
    pulse_clr();

    // Two lines where one is expected.
    send_frame(2, 100, 1, 0);
    check("two lines line_cnt", a_lines, 2);
    check("two lines err_lines", a_err_lines, 1);
    check("two lines err_cnt", a_err_cnt, 1);
    check("two lines err_len", a_err_len, 0);
    pulse_clr();

    // Valid beat with hsync low inside a frame.
    bus.rx_vsync = 1'b1;
    tick();
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check("stray valid err_proto", a_err_proto, 1);
    check("stray valid beat_cnt", a_beats, 100);
    check("stray valid err_cnt", a_err_cnt, 1);
    send_line(100, 1, 0);
    bus.rx_vsync = 1'b0;
    tick();
    check("stray valid frame_cnt", a_frames, 5);
    check("stray valid err_data", a_err_data, 0);
    pulse_clr();

    // Hsync rise while vsync low.
    bus.rx_hsync = 1'b1;
    tick();
    bus.rx_hsync = 1'b0;
    check("hsync outside frame err_proto", a_err_proto, 1);
    check("hsync outside frame frame_cnt", a_frames, 5);
    tick();
    pulse_clr();

    // Two error kinds in one beat, then an error coincident with clr_err.
    bus.rx_vsync = 1'b1;
    tick();
    bus.rx_hsync = 1'b1;
    tick();
    for (int i = 1; i <= 100; i++) begin
      clr_err = (i == 20);
      drive_beat(10'(i), (i == 10 || i == 20) ? 3 : -1, (i == 10) ? 6'h2C : 6'h2B);
      clr_err = 1'b0;
      if (i == 10) begin
        check("dual err_data", a_err_data, 1);
        check("dual err_type", a_err_type, 1);
        check("dual err_cnt", a_err_cnt, 2);
      end
      if (i == 20) begin
        check("clr vs new err_data", a_err_data, 1);
        check("clr vs new err_type", a_err_type, 0);
        check("clr vs new err_cnt", a_err_cnt, 1);
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_hsync = 1'b0;
    bus.rx_vsync = 1'b0;
    tick();
    check("close together err_len", a_err_len, 0);
    check("close together err_lines", a_err_lines, 0);
    check("close together line_cnt", a_lines, 1);
    check("close together frame_cnt", a_frames, 6);
    check("close together err_cnt", a_err_cnt, 1);
    pulse_clr();

    // Pattern starting at 1020 wraps 1023 -> 0 on the FIRST_VAL=1020 instance.
    send_frame(1, 100, 1020, 0);
    check("wrap err_data", b_err_data, 0);
    check("wrap err_cnt", b_err_cnt, 0);
    check("wrap pass", b_pass, 1);
    check("wrap frame_cnt", b_frames, 7);
    check("wrap default inst err_data", a_err_data, 1);
    pulse_clr();

    // Async reset at beat 50, released with vsync still high.
    bus.rx_vsync = 1'b1;
    tick();
    bus.rx_hsync = 1'b1;
    tick();
    for (int i = 1; i <= 49; i++) drive_beat(10'(i), -1, 6'h2B);
    bus.rx_valid = 1'b1;
    bus.rx_data  = {4'h0, {6{10'd50}}};
    #2;
    rst = 1'b1;
    #1;
    check("async rst frame_cnt", a_frames, 0);
    check("async rst beat_cnt", a_beats, 0);
    check("async rst err_data", a_err_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 51; i <= 60; i++) drive_beat(10'(i), -1, 6'h2B);
    check("resync beat_cnt", a_beats, 0);
    check("resync err_proto", a_err_proto, 0);
    check("resync err_cnt", a_err_cnt, 0);
    bus.rx_valid = 1'b0;
    bus.rx_hsync = 1'b0;
    tick();
    bus.rx_vsync = 1'b0;
    tick();
    check("resync frame_done", a_done, 0);
    check("resync frame_cnt", a_frames, 0);
    tick();
    send_frame(1, 100, 1, 0);
    check("post-reset frame_cnt", a_frames, 1);
    check("post-reset beat_cnt", a_beats, 100);
    check("post-reset line_cnt", a_lines, 1);
    check("post-reset pass", a_pass, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
